// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and the fetch-queue entry layout for the instruction-fetch stage.
package if_pkg;

  localparam int FETCH_STEP     = 4;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] instr;
    logic [DEF_ADDR_WIDTH-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Synchronous power-of-two FIFO with flush; the head entry is presented on o_dout
// whenever the queue is non-empty.
module fetch_queue #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & (~o_full | i_pop);
  assign w_do_pop  = i_pop & ~o_empty;

  // NOTE: storage is reset because the head slot is visible on o_dout, which must read 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, selects redirect targets and gates pushes
// of {instr, pc+4} into the decoupling fetch queue.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    FQ_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          branch_taken,
  input  logic [ADDR_WIDTH-1:0]         branch_address,
  input  logic                          jump,
  input  logic [ADDR_WIDTH-1:0]         jump_address,
  output logic [ADDR_WIDTH-1:0]         imem_addr,
  input  logic [DATA_WIDTH-1:0]         imem_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_instr,
  output logic [ADDR_WIDTH-1:0]         out_pc_plus4,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_plus4;
  logic [ADDR_WIDTH-1:0] w_target_raw;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_redirect;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_full;
  logic                  w_empty;
  logic [ENTRY_W-1:0]    w_head;

  // Jump wins over branch; targets are forced word-aligned.
  assign w_redirect   = jump | branch_taken;
  assign w_target_raw = jump ? jump_address : branch_address;
  assign w_target     = w_target_raw & ~ADDR_WIDTH'(3);
  assign w_pc_plus4   = r_pc + ADDR_WIDTH'(FETCH_STEP);

  assign w_pop  = ~w_empty & out_ready;
  assign w_push = en & ~w_redirect & (~w_full | w_pop);

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_pc <= RESET_PC;
    else if (w_redirect) r_pc <= w_target;
    else if (w_push)     r_pc <= w_pc_plus4;
  end

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_din   ({imem_data, w_pc_plus4}),
    .o_dout  (w_head),
    .o_count (fq_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign imem_addr    = r_pc;
  assign out_valid    = ~w_empty;
  assign out_instr    = w_head[ENTRY_W-1 -: DATA_WIDTH];
  assign out_pc_plus4 = w_head[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a queue-level fetch model predicts every entry,
// a separate monitor compares whatever decode accepts.
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int              AW     = DEF_ADDR_WIDTH;
  localparam int              DW     = DEF_DATA_WIDTH;
  localparam int              DEPTH  = 4;
  localparam int              CW     = $clog2(DEPTH + 1);
  localparam logic [AW-1:0]   RST_PC = '0;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          branch_taken;
  logic [AW-1:0] branch_address;
  logic          jump;
  logic [AW-1:0] jump_address;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc_plus4;
  logic [CW-1:0] fq_count;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_entry_t  sb_q[$];
  logic [AW-1:0] m_pc;
  int            m_count;
  bit            mon_en;

  if_fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FQ_DEPTH   (DEPTH),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .jump           (jump),
    .jump_address   (jump_address),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc_plus4   (out_pc_plus4),
    .fq_count       (fq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] imem_f(input logic [AW-1:0] a);
    return 32'h5A00_00C3 ^ {a, a, a, 2'b01};
  endfunction

  assign imem_data = imem_f(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour for one clock edge, evaluated mid-cycle on the current inputs.
  task automatic model_update();
    bit            redir;
    bit            pop;
    bit            push;
    logic [AW-1:0] tgt;
    redir = jump || branch_taken;
    tgt   = jump ? jump_address : branch_address;
    tgt[1:0] = 2'b00;
    pop   = (m_count > 0) && out_ready;
    if (redir) begin
      sb_q.delete();
      m_count = 0;
      m_pc    = tgt;
    end else begin
      push = en && (m_count < DEPTH || pop);
      if (pop) m_count--;
      if (push) begin
        sb_q.push_back('{instr: imem_f(m_pc), pc_plus4: m_pc + AW'(4)});
        m_count++;
        m_pc = m_pc + AW'(4);
      end
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic drive(input bit e, input bit rdy, input bit j, input logic [AW-1:0] ja,
                       input bit b, input logic [AW-1:0] ba);
    en             = e;
    out_ready      = rdy;
    jump           = j;
    jump_address   = ja;
    branch_taken   = b;
    branch_address = ba;
    @(negedge clk);
    #1;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    bit redir;
    bit j;
    bit b;
    redir = ($urandom_range(0, 19) == 0);
    j     = redir && ($urandom_range(0, 1) == 1);
    b     = redir && (!j || ($urandom_range(0, 1) == 1));
    drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, j, AW'($urandom), b, AW'($urandom));
  endtask

  // Monitor: checks registered outputs mid-cycle and scores every accepted entry.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        check("imem_addr", imem_addr, m_pc);
        check("fq_count", fq_count, m_count);
        check("out_valid", out_valid, m_count != 0);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL pop_unexpected: got pc_plus4 0x%0h expected no entry", out_pc_plus4);
          end else begin
            e = sb_q.pop_front();
            check("out_instr", out_instr, e.instr);
            check("out_pc_plus4", out_pc_plus4, e.pc_plus4);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; out_ready = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_address = '0; branch_address = '0;
    m_pc = RST_PC; m_count = 0; mon_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_out_valid", out_valid, 0);
    check("rst_fq_count", fq_count, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc_plus4", out_pc_plus4, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Streaming at one instruction per cycle
    repeat (12) drive(1, 1, 0, '0, 0, '0);

    // Decode back-pressure: queue saturates, fetch stops
    repeat (6) drive(1, 0, 0, '0, 0, '0);
    check("sat_fq_count", fq_count, DEPTH);
    repeat (8) drive(1, 1, 0, '0, 0, '0);

    // Jump beats branch while three entries are queued
    drive(1, 0, 0, '0, 1, 10'h040);
    repeat (3) drive(1, 0, 0, '0, 0, '0);
    check("pre_jump_fq_count", fq_count, 3);
    drive(1, 1, 1, 10'h100, 1, 10'h200);
    check("jump_fq_count", fq_count, 0);
    check("jump_pc", imem_addr, 10'h100);
    repeat (5) drive(1, 1, 0, '0, 0, '0);

    // Stall drains the queue, then a branch during stall still redirects
    drive(1, 0, 0, '0, 1, 10'h080);
    repeat (2) drive(1, 0, 0, '0, 0, '0);
    repeat (3) drive(0, 1, 0, '0, 0, '0);
    check("stall_fq_count", fq_count, 0);
    check("stall_pc_hold", imem_addr, 10'h088);
    drive(0, 1, 0, '0, 1, 10'h003);
    check("stall_branch_pc", imem_addr, 10'h000);
    repeat (4) drive(1, 1, 0, '0, 0, '0);

    // PC wrap at the top of the address space
    drive(1, 1, 1, 10'h3F8, 0, '0);
    repeat (6) drive(1, 1, 0, '0, 0, '0);

    repeat (1500) drive_random();

    // Asynchronous reset mid-cycle with three queued entries
    drive(1, 0, 1, 10'h020, 0, '0);
    repeat (3) drive(1, 0, 0, '0, 0, '0);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_fq_count", fq_count, 0);
    check("async_rst_imem_addr", imem_addr, RST_PC);
    sb_q.delete();
    m_count = 0;
    m_pc    = RST_PC;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    repeat (300) drive_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch stage with a decoupling fetch queue. It owns the program counter, reads the combinational instruction memory every cycle, and buffers up to FQ_DEPTH fetched {instr, pc_plus4} entries for decode over a valid/ready handshake. Branch and jump redirects flush the queue and reload the PC, and `en` stalls fetch without blocking decode. It sits between the instruction memory and the IF/ID boundary, replacing the single-entry fetch path.

## Interface
Parameters:
- ADDR_WIDTH, 10, PC and memory address width
- DATA_WIDTH, 32, instruction width
- FQ_DEPTH, 4, fetch-queue entries; must be a power of two and at least 2
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- en  in  1  fetch enable; 0 = stall fetch (hazard stall)
- branch_taken  in  1  redirect to branch_address
- branch_address  in  ADDR_WIDTH  branch target
- jump  in  1  redirect to jump_address; has priority over branch_taken
- jump_address  in  ADDR_WIDTH  jump target
- imem_addr  out  ADDR_WIDTH  current PC, driven to instruction memory
- imem_data  in  DATA_WIDTH  instruction at imem_addr, same cycle (combinational memory)
- out_valid  out  1  queue head is valid
- out_ready  in  1  decode accepts the head
- out_instr  out  DATA_WIDTH  head instruction
- out_pc_plus4  out  ADDR_WIDTH  head PC + 4
- fq_count  out  $clog2(FQ_DEPTH+1)  current occupancy

## Operation
- Redirect: `redirect = jump | branch_taken`. Target is jump_address if `jump`, else branch_address. Bits [1:0] of the target are forced to 00.
- Push: when `en & ~redirect & (fq_count < FQ_DEPTH | pop)`, the unit pushes {imem_data, pc+4} and sets PC <= PC+4.
- PC wraps modulo 2^ADDR_WIDTH; PC+4 from the top word is 0.
- Pop: `pop = out_valid & out_ready`. Pops are allowed while `en` = 0.
- On redirect, all of the following happen at the edge:
  - The queue is cleared, pointers reset, and fq_count = 0.
  - No push occurs that cycle.
  - PC <= target.
  - A pop in the same cycle is accepted by decode but has no further effect.
- Redirect overrides stall. With `en` = 0 and a redirect, the flush and PC load still occur.
- Stall (`en` = 0, no redirect): PC holds, nothing is pushed, and the queue drains normally.
- Full with a simultaneous pop: the push and pop both occur, and fq_count is unchanged.
- Empty: out_valid = 0. out_instr and out_pc_plus4 hold stale values, which are don't-care.
- Reset values: PC = RESET_PC, imem_addr = RESET_PC, out_valid = 0, fq_count = 0. out_instr and out_pc_plus4 reset to 0.
- Reset asserted mid-stream discards all entries and any redirect in flight.

## Timing
- Fetch-to-output latency is 1 cycle. An entry pushed at edge N is visible at out_* after edge N, with no same-cycle bypass.
- Redirect penalty:
  - Redirect sampled in cycle R.
  - Target fetched in cycle R+1.
  - out_valid is first asserted in cycle R+2.
- out_valid, out_instr, out_pc_plus4 and fq_count are registered, with no combinational path from inputs.
- imem_addr is registered (it is the PC).
- Steady state with out_ready = 1 and en = 1 sustains 1 instruction per cycle.

## Structure
- Package `if_pkg` holds:
  - FETCH_STEP = 4
  - default ADDR_WIDTH and DATA_WIDTH constants
  - the fetch-entry struct {instr, pc_plus4}
- Sub-module `fetch_queue` is a synchronous FIFO, parametrised by width and depth. It has push, pop and flush inputs, and count, full and empty outputs. Flush has priority over push.
- The top level contains the PC register, redirect/target selection, and push gating only.

## Test plan
- Reset then run with en = 1, out_ready = 1, and imem returning {addr}:
  - out_valid rises in cycle 2.
  - out_pc_plus4 sequence is 4, 8, 12, …
  - One entry per cycle.
- out_ready = 0 for 6 cycles, FQ_DEPTH = 4:
  - fq_count saturates at 4 and PC stops at 16.
  - Raising out_ready drains the entries 4, 8, 12, 16 in order, then resumes at 20.
- jump = 1 with jump_address = 0x100, together with branch_taken = 1 and branch_address = 0x200, while the queue holds 3 entries:
  - fq_count = 0 next cycle and PC = 0x100.
  - The first out_pc_plus4 after the redirect is 0x104.
- en = 0 for 3 cycles with 2 entries queued and out_ready = 1:
  - The queue drains to 0 and PC holds.
  - branch_taken during the stall still loads PC from branch_address = 0x03, giving PC = 0x00.
- PC = 0x3FC with ADDR_WIDTH = 10: the next PC is 0 and out_pc_plus4 for that entry is 0.
- Reset asserted asynchronously mid-cycle with 3 entries queued:
  - out_valid = 0 and fq_count = 0 immediately.
  - imem_addr = RESET_PC before the next edge.
